// File: rtl/uart_pkg.sv
// Definitions shared by the board's UART transmit and receive paths.
package uart_pkg;

   localparam int CLK_DIV_115200 = 868;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous byte FIFO feeding the UART transmitter.
// full/empty are registered and change the cycle after the accepted edge.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;

   // The registered full flag gates pushes, so a same-cycle pop never makes room.
   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && !r_empty;

   always_comb begin
      w_count_next = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a byte FIFO in front of the serialiser.
// Frames are sent back to back with no idle gap while the FIFO holds data.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);
   localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

   uart_state_t      r_state;
   uart_state_t      w_state_next;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [CNT_W-1:0] w_clk_cnt_next;
   logic [2:0]       r_bit_cnt;
   logic [2:0]       w_bit_cnt_next;
   logic [7:0]       r_sh;
   logic [7:0]       w_sh_next;
   logic             r_tx;
   logic             w_tx_next;
   logic             w_pop;
   logic             w_bit_last;
   logic [7:0]       w_fifo_dout;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (tx_wr),
      .i_din   (tx_data),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (tx_full),
      .o_empty (tx_empty)
   );

   assign w_bit_last = (r_clk_cnt == CNT_LAST);

   always_comb begin
      w_state_next   = r_state;
      w_clk_cnt_next = r_clk_cnt;
      w_bit_cnt_next = r_bit_cnt;
      w_sh_next      = r_sh;
      w_pop          = 1'b0;
      case (r_state)
         IDLE: begin
            if (!tx_empty) begin
               w_pop          = 1'b1;
               w_sh_next      = w_fifo_dout;
               w_bit_cnt_next = '0;
               w_clk_cnt_next = '0;
               w_state_next   = START;
            end
         end
         START: begin
            if (w_bit_last) begin
               w_clk_cnt_next = '0;
               w_state_next   = DATA;
            end else begin
               w_clk_cnt_next = r_clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (w_bit_last) begin
               w_clk_cnt_next = '0;
               w_sh_next      = {1'b0, r_sh[7:1]};
               if (r_bit_cnt == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
               end
            end else begin
               w_clk_cnt_next = r_clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (w_bit_last) begin
               w_clk_cnt_next = '0;
               // Pop straight into the next start bit to keep frames gapless.
               if (!tx_empty) begin
                  w_pop          = 1'b1;
                  w_sh_next      = w_fifo_dout;
                  w_bit_cnt_next = '0;
                  w_state_next   = START;
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_clk_cnt_next = r_clk_cnt + 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase

      // The pin level follows the state being entered, so the output register
      // changes on the same edge as the FSM.
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_sh_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_sh      <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_clk_cnt <= w_clk_cnt_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_sh      <= w_sh_next;
         r_tx      <= w_tx_next;
      end
   end

   assign tx      = r_tx;
   assign tx_busy = (r_state != IDLE);
   assign tx_done = (r_state == STOP) && w_bit_last;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx: a frame-timer reference model
// predicts every output each cycle and a loopback receiver decodes the line.
module tb_uart_tx;
   localparam int D     = 16;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_wr = 1'b0;
   logic       tx_full, tx_empty, tx_busy, tx_done, tx;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;
   int cyc = 0;
   int rx_count = 0;

   // reference model state
   logic [7:0] m_q[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] m_cur = 8'h00;
   int         m_t = 0;        // cycles left in the current frame, 0 = idle
   int         done_times[$];

   uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_full  (tx_full),
      .tx_empty (tx_empty),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] model_out();
      logic line;
      int   pos;
      line = 1'b1;
      if (m_t != 0) begin
         pos = 10 * D - m_t;
         if (pos < D)           line = 1'b0;
         else if (pos >= 9 * D) line = 1'b1;
         else                   line = m_cur[pos / D - 1];
      end
      return {line, m_t != 0, m_t == 1, m_q.size() == 0, m_q.size() == DEPTH};
   endfunction

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin : model
      int   sz;
      logic full_pre;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_q.delete();
            exp_bytes.delete();
            m_t = 0;
         end else begin
            sz       = m_q.size();
            full_pre = (sz == DEPTH);
            if ((m_t <= 1) && (sz > 0)) begin
               m_cur = m_q.pop_front();
               exp_bytes.push_back(m_cur);
               m_t = 10 * D;
            end else if (m_t > 0) begin
               m_t--;
            end
            if (tx_wr && !full_pre) m_q.push_back(tx_data);
         end
      end
   end

   initial begin : output_checker
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("outputs{tx,busy,done,empty,full}",
                  {27'd0, tx, tx_busy, tx_done, tx_empty, tx_full}, {27'd0, model_out()});
            if (tx_done) done_times.push_back(cyc);
         end
      end
   end

   initial begin : loopback_rx
      logic       prev;
      logic [9:0] fr;
      logic       aborted;
      logic [7:0] want;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset_n || !chk_en) begin
            prev = 1'b1;
            continue;
         end
         if (prev && !tx) begin
            aborted = 1'b0;
            fr = '0;
            for (int c = 0; c < 10 * D; c++) begin
               if (c > 0) @(negedge clk);
               if (!reset_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (c % D == D / 2) fr[c / D] = tx;
            end
            if (!aborted) begin
               check("rx_framing", {30'd0, fr[9], fr[0]}, 32'd2);
               want = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : ~fr[8:1];
               check("rx_byte", {24'd0, fr[8:1]}, {24'd0, want});
               $display("rx frame %0d: byte=%02h expected=%02h", rx_count, fr[8:1], want);
               rx_count++;
            end else begin
               $display("rx frame aborted by reset");
            end
            prev = tx;
         end else begin
            prev = tx;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      tx_wr   = 1'b1;
      tx_data = b;
      step();
      tx_wr = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(m_t == 0 && m_q.size() == 0 && !tx_busy) && n < 20000) begin
         step();
         n++;
      end
      check("idle_reached", {31'd0, n < 20000}, 32'd1);
      repeat (3) step();
   endtask

   initial begin : driver
      logic ok;
      int   n;
      int   len;
      #1;
      reset_n = 1'b0;
      chk_en  = 1'b1;

      // reset held: inputs toggle, outputs stay at reset values
      repeat (10) begin
         step();
         tx_wr   = 1'($urandom);
         tx_data = 8'($urandom);
      end
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_done", {31'd0, tx_done}, 32'd0);
      check("rst_empty", {31'd0, tx_empty}, 32'd1);
      check("rst_full", {31'd0, tx_full}, 32'd0);
      step();
      tx_wr   = 1'b0;
      reset_n = 1'b1;
      ok = 1'b1;
      repeat (1000) begin
         step();
         if (tx !== 1'b1) ok = 1'b0;
      end
      check("idle_tx_high", {31'd0, ok}, 32'd1);

      // single byte: start bit appears one edge after the write is registered
      write_byte(8'h53);
      check("latency_before", {31'd0, tx}, 32'd1);
      step();
      check("latency_start", {31'd0, tx}, 32'd0);
      wait_idle();
      check("single_busy_low", {31'd0, tx_busy}, 32'd0);

      // gapless burst of three
      done_times.delete();
      tx_wr = 1'b1;
      tx_data = 8'h00; step();
      tx_data = 8'hFF; step();
      tx_data = 8'hA5; step();
      tx_wr = 1'b0;
      wait_idle();
      check("burst_done_count", done_times.size(), 32'd3);
      if (done_times.size() == 3) begin
         check("burst_gap1", done_times[1] - done_times[0], 10 * D);
         check("burst_gap2", done_times[2] - done_times[1], 10 * D);
      end

      // overflow: a frame in flight, then 9 writes; the ninth is dropped
      write_byte(8'($urandom));
      repeat (3) step();
      tx_wr = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tx_data = 8'(i);
         step();
         if (i == 8) check("full_after_8", {31'd0, tx_full}, 32'd1);
      end
      tx_wr = 1'b0;
      wait_idle();

      // push landing on the STOP->START pop edge with one byte queued
      tx_wr = 1'b1;
      tx_data = 8'h11; step();
      tx_data = 8'h22; step();
      tx_wr = 1'b0;
      n = 0;
      while (!(m_t == 1 && m_q.size() == 1) && n < 20 * D) begin
         step();
         n++;
      end
      check("pushpop_reached", {31'd0, n < 20 * D}, 32'd1);
      write_byte(8'h33);
      check("pushpop_not_empty", {31'd0, tx_empty}, 32'd0);
      check("pushpop_not_full", {31'd0, tx_full}, 32'd0);
      wait_idle();

      // reset during data bit 3, with another byte still queued
      tx_wr = 1'b1;
      tx_data = 8'($urandom); step();
      tx_data = 8'($urandom); step();
      tx_wr = 1'b0;
      n = 0;
      while (m_t != (6 * D - D / 2) && n < 20 * D) begin
         step();
         n++;
      end
      check("midrst_reached", {31'd0, n < 20 * D}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_tx", {31'd0, tx}, 32'd1);
      check("midrst_busy", {31'd0, tx_busy}, 32'd0);
      repeat (3) step();
      reset_n = 1'b1;
      ok = 1'b1;
      repeat (50) begin
         step();
         if (tx !== 1'b1) ok = 1'b0;
      end
      check("midrst_idle_tx", {31'd0, ok}, 32'd1);
      check("midrst_empty", {31'd0, tx_empty}, 32'd1);
      write_byte(8'h3C);
      wait_idle();

      // randomised bursts with random gaps
      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(1, 11);
         for (int k = 0; k < len; k++) begin
            tx_wr   = ($urandom_range(0, 3) != 0);
            tx_data = 8'($urandom);
            step();
         end
         tx_wr = 1'b0;
         repeat ($urandom_range(0, 12 * D)) step();
      end
      wait_idle();

      repeat (5) step();
      check("rx_drain", exp_bytes.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit counterpart of the board's USB-UART receive path. It accepts bytes from game logic (score/status reports to the host) into a small FIFO and serialises them as 8N1 frames, LSB first, on the USB-UART TX pin. Throughput is 115200 baud at the 100 MHz system clock. Consecutive frames are sent gaplessly while the FIFO holds data.

## Interface
- CLK_DIV, 868: clock cycles per bit (100 MHz / 115200).
- FIFO_DEPTH, 8: bytes of buffering. Must be a power of two, at least 2.

- clk  in  1  100 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send; sampled when tx_wr is high
- tx_wr  in  1  write strobe, one byte per cycle
- tx_full  out  1  FIFO full; writes are ignored while high
- tx_empty  out  1  FIFO holds no bytes
- tx_busy  out  1  frame in progress (state ≠ IDLE)
- tx_done  out  1  one-cycle pulse at the end of each stop bit
- tx  out  1  serial line; idles high

## Operation
- Reset (async assert, sync release): FIFO emptied, state IDLE, tx=1, tx_busy=0, tx_done=0, tx_empty=1, tx_full=0.
- Write acceptance: a write is accepted when tx_wr=1 and tx_full=0 at the edge. A write while full is dropped silently and leaves the FIFO unchanged. tx_full is the registered value, so a pop in the same cycle does not make room.
- Push and pop in the same cycle (not full): count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if FIFO not empty, pop the head into shift register sh, set bit_cnt=0, clk_cnt=0, go to START.
- START: tx=0 for CLK_DIV cycles, then go to DATA.
- DATA: tx=sh[0] for CLK_DIV cycles, then shift right. After bit_cnt=7 completes, go to STOP; otherwise increment bit_cnt.
- STOP: tx=1 for CLK_DIV cycles. At the final cycle, pulse tx_done. If the FIFO is not empty, pop and go directly to START (gapless). Otherwise go to IDLE.
- tx is driven from a register: no combinational path from FSM to pin.
- Widths: clk_cnt is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. count is $clog2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-frame: tx returns high immediately (async) and the in-flight byte is lost.

## Timing
- Write-to-start latency: write sampled at edge k → FIFO non-empty after k → FSM pops at edge k+1 and tx falls at k+1 (registered).
- Frame length: exactly 10·CLK_DIV cycles from the falling edge of tx to the end of the stop bit.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle. The frame period is exactly 10·CLK_DIV.
- tx_done: high for exactly one cycle, coincident with the last stop-bit cycle.
- tx_busy: high from the first start-bit cycle through the last stop-bit cycle, and stays high across gapless frames.
- tx_empty/tx_full: registered, and update the cycle after the accepted push/pop edge.

## Structure
- Shared package uart_pkg:
  - CLK_DIV_115200=868 (shared with the receiver)
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}
- Sub-module uart_tx_fifo: synchronous FIFO (FIFO_DEPTH×8) with push, pop, dout (head, show-ahead), full, empty.
- uart_tx holds the FSM, baud counter and shift register.

## Test plan
- Reset check: hold reset_n=0, toggle inputs → tx=1, tx_busy=0, tx_done=0, tx_empty=1, tx_full=0. Release, idle 1000 cycles → tx stays 1.
- Single byte: write 8'h53 ('S') → tx falls one edge after the write is registered. Line sequence 0,1,1,0,0,1,0,1,0,1, each bit 868 cycles. One tx_done pulse. tx_busy low afterwards. A loopback through the receiver returns 8'h53.
- Gapless burst: write 8'h00, 8'hFF, 8'hA5 on consecutive cycles → three frames with no idle cycle between stop and next start. Total 3·8680 cycles. Three tx_done pulses 8680 cycles apart.
- Full/overflow: with a frame in progress, write 9 more bytes 8'h01..8'h09 → tx_full asserts after the 8th. 8'h09 is dropped. Exactly 8'h01..8'h08 are transmitted after the current frame.
- Simultaneous push/pop: time a write to land on the STOP→START pop edge with count=1 → count unchanged, no byte lost or duplicated, order preserved.
- Mid-frame reset: assert reset_n=0 during DATA bit 3 → tx=1 immediately. After release, tx stays idle and tx_empty=1. A new write 8'h3C transmits correctly.
